// File: rtl/demux14_router.sv
// 1-to-4 steering block: each source word lands in one channel holding register,
// or in all four at once on broadcast, with independent valid/ready per channel.

module demux14_chan #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_ready,
    output logic             can_accept,
    output logic             valid,
    output logic [WIDTH-1:0] data
);
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    // A write landing in the same cycle as a drain wins, so the channel sustains one word per cycle.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (wr_en) begin
            valid_d = 1'b1;
            data_d  = wr_data;
        end else if (rd_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign can_accept = !valid_q || rd_ready;
    assign valid      = valid_q;
    assign data       = data_q;
endmodule

module demux14_router #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    input  logic             in_bcast,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data_0,
    output logic [WIDTH-1:0] out_data_1,
    output logic [WIDTH-1:0] out_data_2,
    output logic [WIDTH-1:0] out_data_3,
    output logic [CNT_W-1:0] xfer_count
);
    localparam int NUM_CH = 4;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [1:0]       sel;
        logic             bcast;
    } req_t;

    req_t                           req;
    logic [NUM_CH-1:0]              can;
    logic [NUM_CH-1:0]              wr_en;
    logic [NUM_CH-1:0][WIDTH-1:0]   ch_data;
    logic                           accept;
    logic [CNT_W-1:0]               cnt_q, cnt_d;

    assign req = '{data: in_data, sel: in_sel, bcast: in_bcast};

    // in_ready deliberately ignores in_valid so the producer can look ahead.
    always_comb begin
        in_ready = req.bcast ? (&can) : can[req.sel];
    end

    assign accept = in_valid && in_ready;

    always_comb begin
        wr_en = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            wr_en[k] = accept && (req.bcast || (req.sel == 2'(k)));
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ch
            demux14_chan #(.WIDTH(WIDTH)) u_chan (
                .clk        (clk),
                .rst_n      (rst_n),
                .wr_en      (wr_en[g]),
                .wr_data    (req.data),
                .rd_ready   (out_ready[g]),
                .can_accept (can[g]),
                .valid      (out_valid[g]),
                .data       (ch_data[g])
            );
        end
    endgenerate

    // A broadcast is one accepted word, so it counts once.
    always_comb begin
        cnt_d = cnt_q;
        if (accept) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign xfer_count = cnt_q;
    assign out_data_0 = ch_data[0];
    assign out_data_1 = ch_data[1];
    assign out_data_2 = ch_data[2];
    assign out_data_3 = ch_data[3];
endmodule

// File: doc/demux14_router.md
Name: demux14_router

Overview:
- 1-to-4 steering block for 16-bit signed datapath words. It performs the inverse of the 4:1 operand select: it takes one source stream and delivers each word to one of four destination channels, or to all four at once.
- Each destination has a one-word holding register with a valid/ready handshake, so a stalled consumer does not corrupt the other channels.
- It sits between a single producer (ALU result or memory read-data path) and four consumers (register-file write ports, PC, output latch, and similar).

Parameters:
- WIDTH, 16, data word width in bits; words are signed and passed through unmodified.
- CNT_W, 16, width of the accepted-word counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising clk edge.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  block accepts the word this cycle.
- in_data  input  WIDTH  signed word to route.
- in_sel  input  2  destination channel, 0..3.
- in_bcast  input  1  1 means write to all four channels and ignore in_sel.
- out_valid  output  4  bit k means channel k holds a word.
- out_ready  input  4  bit k means consumer k takes the word this cycle.
- out_data_0, out_data_1, out_data_2, out_data_3  output  WIDTH each  channel holding registers.
- xfer_count  output  CNT_W  number of accepted input words; wraps.

Behaviour:
- Reset, sampled on clk when rst_n=0:
  - out_valid = 0.
  - All out_data_k = 0.
  - xfer_count = 0.
  - Any held words are discarded, including during a stall. No transfer completes in the reset cycle.
- Channel k can accept when it is empty or being drained this cycle: can_k = !out_valid[k] | out_ready[k].
- in_ready rule:
  - in_bcast=0: in_ready = can_{in_sel}.
  - in_bcast=1: in_ready = can_0 & can_1 & can_2 & can_3.
  - in_ready is a combinational function of out_valid, out_ready, in_sel and in_bcast, with no dependence on in_valid. This combinational path is intentional.
- Accept occurs when in_valid & in_ready at the clock edge. in_data, in_sel and in_bcast are sampled only at the accept edge. They may change freely while the block is stalled.
- Write on accept:
  - in_bcast=0: out_data_{in_sel} <= in_data and out_valid[in_sel] <= 1.
  - in_bcast=1: all four channels are written and all four valids are set.
  - Latency is 1 cycle from the accept edge to out_valid high.
- Drain: on out_valid[k] & out_ready[k] with no simultaneous write to k, out_valid[k] <= 0. out_data_k holds its last value; it is not cleared.
- Simultaneous drain and write to the same channel: the new word loads and out_valid[k] stays 1. Full throughput is 1 word per cycle per channel.
- Stall: while out_valid[k] & !out_ready[k], out_data_k and out_valid[k] hold stable. A write to k is refused because in_ready=0. Words to other channels still flow.
- Independence: the channels drain independently. out_ready[k] while out_valid[k]=0 has no effect.
- No reordering within a channel. There is no ordering guarantee across channels.
- xfer_count increments by 1 per accepted input word, and a broadcast counts as 1. It wraps from 2^CNT_W-1 to 0 without a flag.
- in_valid=0 causes no state change other than drains.
- There is no sign extension, arithmetic or width change on data.

Test Plan:
- Reset, then send 0x1234 with in_sel=2 and all out_ready=1 -> in_ready=1. Next cycle out_valid=4'b0100, out_data_2=0x1234, xfer_count=1. The cycle after, out_valid=0.
- Hold out_ready[1]=0. Send 0x0AAA to ch1, then 0x0BBB to ch1, then 0x0CCC to ch3 -> second word stalls with in_ready=0 and out_data_1 stays 0x0AAA. While stalled, switch in_sel to 3 -> 0x0CCC is accepted and out_valid[3]=1. Then raise out_ready[1] -> 0x0BBB accepted, xfer_count=3.
- Broadcast 0x8001 (negative) with out_ready[0]=0 and ch0 full -> in_ready=0. Release ch0 -> accepted, all four out_data=0x8001, out_valid=4'hF, count +1.
- Back-to-back 0x0001..0x0008 to ch0 with out_ready[0]=1 -> in_ready stays 1 every cycle, ch0 delivers 8 words in order, one per cycle.
- Assert rst_n=0 for one cycle while ch2 is full and stalled -> out_valid=0, all data 0, count 0, and no spurious transfer afterward.
- Preload xfer_count via 65535 accepts (or CNT_W=4 with 15 accepts) -> the next accept wraps the count to 0.
